// File: rtl/game_state_fsm.sv
// Game-outcome tracker: counts rising edges of winner/loser flags, ends the game at MAX_HITS.
// Optional macro GAME_STATE_SCORE_OUT_EN exposes the live win/lose counters as outputs.
module game_state_fsm #(
  parameter int MAX_HITS = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winner_flag,
  input  logic             loser_flag,
  output logic             gameover,
`ifdef GAME_STATE_SCORE_OUT_EN
  output logic             who,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] lose_cnt
`else
  output logic             who
`endif
);

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_HITS);

  state_t           r_state;
  logic             r_win_d;
  logic             r_lose_d;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_lose_cnt;
  logic             r_gameover;
  logic             r_who;

  logic             w_win_rise;
  logic             w_lose_rise;
  logic [CNT_W-1:0] w_win_next;
  logic [CNT_W-1:0] w_lose_next;

  assign w_win_rise  = winner_flag & ~r_win_d;
  assign w_lose_rise = loser_flag  & ~r_lose_d;
  assign w_win_next  = r_win_cnt  + CNT_W'(w_win_rise);
  assign w_lose_next = r_lose_cnt + CNT_W'(w_lose_rise);

  // The game stops exactly at LP_MAX, so the counters can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PLAY;
      r_win_d    <= 1'b0;
      r_lose_d   <= 1'b0;
      r_win_cnt  <= '0;
      r_lose_cnt <= '0;
      r_gameover <= 1'b0;
      r_who      <= 1'b0;
    end else begin
      r_win_d  <= winner_flag;
      r_lose_d <= loser_flag;
      case (r_state)
        ST_PLAY: begin
          r_win_cnt  <= w_win_next;
          r_lose_cnt <= w_lose_next;
          // Winner is tested first so a simultaneous finish goes to the winner side.
          if (w_win_next == LP_MAX) begin
            r_state    <= ST_OVER;
            r_gameover <= 1'b1;
            r_who      <= 1'b1;
          end else if (w_lose_next == LP_MAX) begin
            r_state    <= ST_OVER;
            r_gameover <= 1'b1;
            r_who      <= 1'b0;
          end
        end
        ST_OVER: begin
          r_state    <= ST_OVER;
          r_gameover <= 1'b1;
        end
        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

  assign gameover = r_gameover;
  assign who      = r_who;
`ifdef GAME_STATE_SCORE_OUT_EN
  assign win_cnt  = r_win_cnt;
  assign lose_cnt = r_lose_cnt;
`endif

endmodule

// File: tb/tb_game_state_fsm.sv
// Bench for game_state_fsm: directed scenarios plus random games against a tally-based model.
module tb_game_state_fsm;
  localparam int MAX_HITS = 15;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic winner_flag;
  logic loser_flag;
  logic gameover;
  logic who;
`ifdef GAME_STATE_SCORE_OUT_EN
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] lose_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model: plain tallies of observed 0->1 events
  int m_wins;
  int m_losses;
  bit m_prev_w;
  bit m_prev_l;
  bit m_over;
  bit m_who;

  game_state_fsm #(.MAX_HITS(MAX_HITS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winner_flag (winner_flag),
    .loser_flag  (loser_flag),
    .gameover    (gameover),
`ifdef GAME_STATE_SCORE_OUT_EN
    .who         (who),
    .win_cnt     (win_cnt),
    .lose_cnt    (lose_cnt)
`else
    .who         (who)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wins   = 0;
    m_losses = 0;
    m_prev_w = 1'b0;
    m_prev_l = 1'b0;
    m_over   = 1'b0;
    m_who    = 1'b0;
  endtask

  task automatic model_clock();
    if (!m_over) begin
      if (winner_flag && !m_prev_w) m_wins++;
      if (loser_flag && !m_prev_l)  m_losses++;
      if (m_wins == MAX_HITS) begin
        m_over = 1'b1;
        m_who  = 1'b1;
      end else if (m_losses == MAX_HITS) begin
        m_over = 1'b1;
        m_who  = 1'b0;
      end
    end
    m_prev_w = winner_flag;
    m_prev_l = loser_flag;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gameover"}, gameover, m_over);
    check({tag, ".who"}, who, m_who);
`ifdef GAME_STATE_SCORE_OUT_EN
    check({tag, ".win_cnt"}, win_cnt, m_wins);
    check({tag, ".lose_cnt"}, lose_cnt, m_losses);
`endif
  endtask

  // Called at a negedge: apply flags, clock once, check, return at the next negedge.
  task automatic step(input logic w, input logic l, input string tag);
    winner_flag = w;
    loser_flag  = l;
    @(posedge clk);
    model_clock();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset, check outputs before any clock, release at next negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".async_gameover"}, gameover, 1'b0);
    check({tag, ".async_who"}, who, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b1;
    winner_flag = 1'b0;
    loser_flag  = 1'b0;
    model_reset();
    @(negedge clk);

    // reset with winner_flag already high; it counts on the first edge after release
    winner_flag = 1'b1;
    do_reset("rst0");

    // held flag counts once
    step(1'b1, 1'b0, "held1");
    step(1'b1, 1'b0, "held2");
    step(1'b0, 1'b0, "held3");
    check("held_not_over", gameover, 1'b0);

    // 14 more separate winner pulses -> game over on the 15th
    for (int i = 2; i <= MAX_HITS; i++) begin
      step(1'b1, 1'b0, $sformatf("winpulse%0d", i));
      if (i == MAX_HITS - 1) check("win_pulse14_not_over", gameover, 1'b0);
      step(1'b0, 1'b0, $sformatf("winlow%0d", i));
    end
    check("win_over", gameover, 1'b1);
    check("win_who", who, 1'b1);

    // reset while over: must clear without a clock edge
    do_reset("rst_after_win");

    // loser wins with 14 interleaved winner pulses
    for (int i = 0; i < MAX_HITS; i++) begin
      if (i < MAX_HITS - 1) begin
        step(1'b1, 1'b0, "ilv_w");
        step(1'b0, 1'b0, "ilv_wl");
      end
      step(1'b0, 1'b1, "ilv_l");
      step(1'b0, 1'b0, "ilv_ll");
    end
    check("lose_over", gameover, 1'b1);
    check("lose_who", who, 1'b0);

    // sticky: flag toggling after game over changes nothing
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, "sticky_hi");
      step(1'b0, 1'b0, "sticky_lo");
    end
    check("sticky_over", gameover, 1'b1);
    check("sticky_who", who, 1'b0);

    // tie: both at 14, then simultaneous final edges -> winner priority
    do_reset("rst_tie");
    for (int i = 0; i < MAX_HITS - 1; i++) begin
      step(1'b1, 1'b1, "tie_hi");
      step(1'b0, 1'b0, "tie_lo");
    end
    check("tie_pre_over", gameover, 1'b0);
    step(1'b1, 1'b1, "tie_final");
    check("tie_over", gameover, 1'b1);
    check("tie_who", who, 1'b1);

    // random games with occasional mid-game resets
    for (int g = 0; g < 6; g++) begin
      winner_flag = 1'($urandom_range(0, 1));
      loser_flag  = 1'($urandom_range(0, 1));
      do_reset("rst_rand");
      for (int c = 0; c < 90; c++) begin
        if ($urandom_range(0, 59) == 0) begin
          do_reset("rst_mid");
        end else begin
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
